// File: rtl/dual_priority_encoder_pkg.sv
// Shared constants for the dual priority encoder.
//   DPE_N     : default request vector width
//   DPE_W     : default code width (2**DPE_W >= DPE_N)
//   CODE_NONE : code driven whenever a result is not valid
package dual_priority_encoder_pkg;
  localparam int DPE_N     = 12;
  localparam int DPE_W     = 4;
  localparam int CODE_NONE = 0;
endpackage

// File: rtl/dual_priority_encoder_priority_find_first.sv
// priority_find_first: combinational MSB-first priority finder.
// Ports:
//   vec    in  N  request vector, vec[N-1] has highest priority
//   code   out W  code k of winning bit vec[N-1-k]; CODE_NONE if none set
//   found  out 1  at least one bit of vec set
//   onehot out N  one-hot mask of the winning bit; '0 if none set
module priority_find_first
  import dual_priority_encoder_pkg::*;
#(
  parameter int N = DPE_N,
  parameter int W = DPE_W
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] code,
  output logic         found,
  output logic [N-1:0] onehot
);

  // Scan LSB to MSB so the highest set bit is the last to overwrite.
  always_comb begin
    code   = W'(CODE_NONE);
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) begin
        code      = W'(N - 1 - int'(i));
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

  assign found = |vec;

endmodule

// File: rtl/dual_priority_encoder.sv
// dual_priority_encoder: registered two-winner priority picker, latency 1.
// Ports:
//   clk    in  1  rising-edge clock
//   reset  in  1  synchronous active-high reset, clears all outputs
//   A      in  N  request vector, A[N-1] highest priority (code 0)
//   Y_1    out W  code of highest-priority set bit (0 when V_1=0)
//   Y_2    out W  code of second-highest set bit (0 when V_2=0)
//   V_1    out 1  at least one bit of A set
//   V_2    out 1  at least two bits of A set
module dual_priority_encoder
  import dual_priority_encoder_pkg::*;
#(
  parameter int N = DPE_N,
  parameter int W = DPE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] A,
  output logic [W-1:0] Y_1,
  output logic [W-1:0] Y_2,
  output logic         V_1,
  output logic         V_2
);

  logic [W-1:0] code1, code2;
  logic         found1, found2;
  logic [N-1:0] onehot1, onehot2_unused;
  logic [N-1:0] masked;

  logic [W-1:0] y1_d, y1_q, y2_d, y2_q;
  logic         v1_d, v1_q, v2_d, v2_q;

  priority_find_first #(.N(N), .W(W)) u_first (
    .vec    (A),
    .code   (code1),
    .found  (found1),
    .onehot (onehot1)
  );

  // Second winner: remove the first winner and re-encode.
  assign masked = A & ~onehot1;

  priority_find_first #(.N(N), .W(W)) u_second (
    .vec    (masked),
    .code   (code2),
    .found  (found2),
    .onehot (onehot2_unused)
  );

  always_comb begin
    y1_d = code1;
    y2_d = code2;
    v1_d = found1;
    v2_d = found2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y1_q <= W'(CODE_NONE);
      y2_q <= W'(CODE_NONE);
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      y1_q <= y1_d;
      y2_q <= y2_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  assign Y_1 = y1_q;
  assign Y_2 = y2_q;
  assign V_1 = v1_q;
  assign V_2 = v2_q;

endmodule

// File: tb/tb_dual_priority_encoder.sv
module tb_dual_priority_encoder;
  localparam int N = 12;
  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] A;
  logic [W-1:0] Y_1, Y_2;
  logic         V_1, V_2;

  int n_checks;
  int n_fail;

  dual_priority_encoder #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .Y_1   (Y_1),
    .Y_2   (Y_2),
    .V_1   (V_1),
    .V_2   (V_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk from the MSB, first set bit -> y1, second -> y2.
  task automatic model(input logic [N-1:0] a, input logic rst,
                       output logic [W-1:0] y1, output logic [W-1:0] y2,
                       output logic v1, output logic v2);
    int cnt;
    cnt = 0;
    y1 = '0; y2 = '0; v1 = 1'b0; v2 = 1'b0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (a[N-1-k]) begin
          if (cnt == 0) begin y1 = W'(k); v1 = 1'b1; end
          else if (cnt == 1) begin y2 = W'(k); v2 = 1'b1; end
          cnt++;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] ey1, input logic [W-1:0] ey2,
                       input logic ev1, input logic ev2);
    n_checks++;
    assert (Y_1 === ey1) else begin
      n_fail++;
      $error("FAIL %s Y_1 observed=%0d expected=%0d", tag, Y_1, ey1);
    end
    n_checks++;
    assert (Y_2 === ey2) else begin
      n_fail++;
      $error("FAIL %s Y_2 observed=%0d expected=%0d", tag, Y_2, ey2);
    end
    n_checks++;
    assert (V_1 === ev1) else begin
      n_fail++;
      $error("FAIL %s V_1 observed=%0b expected=%0b", tag, V_1, ev1);
    end
    n_checks++;
    assert (V_2 === ev2) else begin
      n_fail++;
      $error("FAIL %s V_2 observed=%0b expected=%0b", tag, V_2, ev2);
    end
  endtask

  // Drive on the falling edge, let one rising edge capture, sample on the next falling edge.
  task automatic step(input logic [N-1:0] a, input logic rst);
    A = a;
    reset = rst;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W-1:0] ey1, ey2;
  logic         ev1, ev2;
  logic [N-1:0] rv;
  logic         rr;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    A = '0;
    reset = 1'b1;
    @(negedge clk);

    step(12'hFFF, 1'b1);           check("reset_cyc1", 4'd0, 4'd0, 1'b0, 1'b0);
    step(12'hFFF, 1'b1);           check("reset_cyc2", 4'd0, 4'd0, 1'b0, 1'b0);

    step(12'b1000_0000_0000, 1'b0); check("single_msb", 4'd0, 4'd0, 1'b1, 1'b0);
    step(12'b0001_0000_0000, 1'b0); check("single_b8",  4'd3, 4'd0, 1'b1, 1'b0);
    step(12'b0000_0000_0001, 1'b0); check("single_lsb", 4'd11, 4'd0, 1'b1, 1'b0);
    step(12'b1100_0000_0000, 1'b0); check("pair_11_10", 4'd0, 4'd1, 1'b1, 1'b1);
    step(12'b0111_0000_0000, 1'b0); check("three_top",  4'd1, 4'd2, 1'b1, 1'b1);
    step(12'b1001_0000_0000, 1'b0); check("pair_11_8",  4'd0, 4'd3, 1'b1, 1'b1);
    step(12'b0000_0000_0011, 1'b0); check("pair_lsbs",  4'd10, 4'd11, 1'b1, 1'b1);
    step(12'h000, 1'b0);            check("zero",       4'd0, 4'd0, 1'b0, 1'b0);
    step(12'hFFF, 1'b0);            check("all_ones",   4'd0, 4'd1, 1'b1, 1'b1);
    step(12'b1000_0000_0001, 1'b0); check("msb_lsb",    4'd0, 4'd11, 1'b1, 1'b1);
    step(12'b0100_1010_0000, 1'b1); check("reset_mid",  4'd0, 4'd0, 1'b0, 1'b0);
    step(12'b0100_1010_0000, 1'b0); check("post_reset", 4'd1, 4'd4, 1'b1, 1'b1);

    // Back-to-back random stream with a single-cycle reset mid-stream.
    for (int i = 0; i < 1000; i++) begin
      case (i % 4)
        0:       rv = N'($urandom);
        1:       rv = N'($urandom & $urandom);
        2:       rv = N'($urandom & $urandom & $urandom);
        default: rv = N'(1) << $urandom_range(N - 1, 0);
      endcase
      rr = (i == 500);
      model(rv, rr, ey1, ey2, ev1, ev2);
      step(rv, rr);
      check($sformatf("rand%0d", i), ey1, ey2, ev1, ev2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
